full_idct_transform: RTL

FULL_IDCT_TRANSFORM -- requirements
Module: full_idct_transform

---
 rtl/full_idct_transform.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/full_idct_transform.sv
// -----------------------------------------------------------------------------
// full_idct_transform
// 8-point orthonormal inverse DCT, computed as eight parallel MAC lanes that
// walk through the coefficients one index per cycle.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   en, cs               start request; a start is taken only when both are 1
//                        and the block is ready
//   integer_Z0..Z7       signed 12-bit DCT coefficients k = 0..7
//   ready                1 when a start can be accepted (IDLE or DONE)
//   out_valid            one-cycle pulse marking freshly loaded samples
//   output0..output7     signed 8-bit reconstructed samples n = 0..7
//
// Timing: start sampled at edge T, MAC runs k = 0..7 on edges T+1..T+8,
// DONE occupies the cycle after T+8, and at edge T+9 the rounded results are
// loaded together with out_valid. A start accepted during DONE (edge T+9)
// gives a new transform every 9 cycles.
// -----------------------------------------------------------------------------
module full_idct_transform (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cs,
    input  logic signed [11:0] integer_Z0,
    input  logic signed [11:0] integer_Z1,
    input  logic signed [11:0] integer_Z2,
    input  logic signed [11:0] integer_Z3,
    input  logic signed [11:0] integer_Z4,
    input  logic signed [11:0] integer_Z5,
    input  logic signed [11:0] integer_Z6,
    input  logic signed [11:0] integer_Z7,
    output logic              ready,
    output logic              out_valid,
    output logic signed [7:0] output0,
    output logic signed [7:0] output1,
    output logic signed [7:0] output2,
    output logic signed [7:0] output3,
    output logic signed [7:0] output4,
    output logic signed [7:0] output5,
    output logic signed [7:0] output6,
    output logic signed [7:0] output7
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 512*cos(m*pi/16) for m = 0..8, rounded to nearest.
    function automatic logic signed [11:0] cos_base(input logic [3:0] m);
        case (m)
            4'd0:    cos_base = 12'sd512;
            4'd1:    cos_base = 12'sd502;
            4'd2:    cos_base = 12'sd473;
            4'd3:    cos_base = 12'sd426;
            4'd4:    cos_base = 12'sd362;
            4'd5:    cos_base = 12'sd284;
            4'd6:    cos_base = 12'sd196;
            4'd7:    cos_base = 12'sd100;
            4'd8:    cos_base = 12'sd0;
            default: cos_base = 12'sd0;
        endcase
    endfunction

    // C[n][k]: the angle index (2n+1)*k is folded modulo 32 onto the first
    // quadrant table, with the sign set by the quadrant. k = 0 carries the
    // 1/sqrt(2) normalisation and is a flat 362.
    function automatic logic signed [11:0] idct_coef(input logic [2:0] n,
                                                     input logic [2:0] k);
        logic [4:0] m;
        m = 5'({2'b00, n, 1'b1} * {3'b000, k});
        if (k == 3'd0) begin
            idct_coef = 12'sd362;
        end else if (m <= 5'd8) begin
            idct_coef = cos_base(4'(m));
        end else if (m <= 5'd16) begin
            idct_coef = -cos_base(4'(5'd16 - m));
        end else if (m <= 5'd24) begin
            idct_coef = -cos_base(4'(m - 5'd16));
        end else begin
            idct_coef = cos_base(4'(6'd32 - {1'b0, m}));
        end
    endfunction

    // Round to nearest (add half an LSB, arithmetic shift), then clamp to int8.
    function automatic logic signed [7:0] round_sat(input logic signed [26:0] acc);
        logic signed [26:0] shifted;
        shifted = (acc + 27'sd512) >>> 10;
        if (shifted > 27'sd127) begin
            round_sat = 8'sh7F;
        end else if (shifted < -27'sd128) begin
            round_sat = 8'sh80;
        end else begin
            round_sat = shifted[7:0];
        end
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic               ready_r;
    logic               out_valid_r;
    logic [2:0]         k_r;
    logic signed [11:0] z_in_s  [0:7];
    logic signed [11:0] z_r     [0:7];
    logic signed [11:0] z_sel_s;
    logic signed [11:0] coef_s  [0:7];
    logic signed [23:0] prod_s  [0:7];
    logic signed [26:0] acc_r   [0:7];
    logic signed [7:0]  out_r   [0:7];
    logic               start_s;
    logic               acc_en_s;
    logic               load_s;

    // Gather the coefficient ports into an indexable array.
    always_comb begin
        z_in_s[0] = integer_Z0;
        z_in_s[1] = integer_Z1;
        z_in_s[2] = integer_Z2;
        z_in_s[3] = integer_Z3;
        z_in_s[4] = integer_Z4;
        z_in_s[5] = integer_Z5;
        z_in_s[6] = integer_Z6;
        z_in_s[7] = integer_Z7;
    end

    // State register; ready is registered from the next state so it is
    // already low in the first MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != MAC);
        end
    end

    // Next-state logic: eight MAC cycles, one DONE cycle, optional chaining.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC: begin
                if (k_r == 3'd7) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MAC;
                end
            end
            DONE: begin
                if (start_s) begin
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Control decode: start is only possible while ready (IDLE or DONE).
    always_comb begin
        start_s  = en & cs & ready_r;
        acc_en_s = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            IDLE:    begin acc_en_s = 1'b0; load_s = 1'b0; end
            MAC:     begin acc_en_s = 1'b1; load_s = 1'b0; end
            DONE:    begin acc_en_s = 1'b0; load_s = 1'b1; end
            default: begin acc_en_s = 1'b0; load_s = 1'b0; end
        endcase
    end

    // One coefficient per cycle feeds all eight lanes with their own constant.
    always_comb begin
        z_sel_s = z_r[k_r];
        for (int n = 0; n < 8; n++) begin
            coef_s[n] = idct_coef(3'(n), k_r);
            prod_s[n] = z_sel_s * coef_s[n];
        end
    end

    // Datapath: capture on start, accumulate during MAC, load results in DONE.
    // Capture and load can coincide when a start is chained out of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r         <= 3'd0;
            out_valid_r <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                z_r[n]   <= 12'sd0;
                acc_r[n] <= 27'sd0;
                out_r[n] <= 8'sd0;
            end
        end else begin
            if (start_s) begin
                k_r <= 3'd0;
                for (int n = 0; n < 8; n++) begin
                    z_r[n]   <= z_in_s[n];
                    acc_r[n] <= 27'sd0;
                end
            end else if (acc_en_s) begin
                k_r <= k_r + 3'd1;
                for (int n = 0; n < 8; n++) begin
                    acc_r[n] <= acc_r[n] + 27'(prod_s[n]);
                end
            end else begin
                k_r <= k_r;
            end

            if (load_s) begin
                out_valid_r <= 1'b1;
                for (int n = 0; n < 8; n++) begin
                    out_r[n] <= round_sat(acc_r[n]);
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign ready     = ready_r;
    assign out_valid = out_valid_r;
    assign output0   = out_r[0];
    assign output1   = out_r[1];
    assign output2   = out_r[2];
    assign output3   = out_r[3];
    assign output4   = out_r[4];
    assign output5   = out_r[5];
    assign output6   = out_r[6];
    assign output7   = out_r[7];

endmodule
